trap_controller: RTL and testbench

//  Machine-mode trap sequencer alongside the ALU. At an instruction boundary it

---
 rtl/trap_controller_if.sv | 51 +++++
 rtl/trap_controller.sv | 167 ++++++++++++++++
 tb/tb_trap_controller.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_if.sv
// ---------------------------------------------------------------------------
// trap_if
//  Bundle of the signals between the CPU core and the machine-mode trap
//  sequencer: boundary/exception/interrupt inputs, current CSR values,
//  the shared CSR write port and the PC redirect.
//  master : CPU side (drives i_*, observes o_*)
//  slave  : trap_controller side (observes i_*, drives o_*)
// ---------------------------------------------------------------------------
interface trap_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    logic              i_boundary;
    logic [XLEN-1:0]   i_pc;
    logic              i_exc_illegal;
    logic              i_exc_ebreak;
    logic              i_exc_ecall;
    logic              i_mret;
    logic              i_irq_msip;
    logic              i_irq_mtip;
    logic              i_irq_meip;
    logic [XLEN-1:0]   i_mstatus;
    logic [XLEN-1:0]   i_mie;
    logic [XLEN-1:0]   i_mtvec;
    logic [XLEN-1:0]   i_mepc;

    logic              o_trap_take;
    logic              o_trap_busy;
    logic              o_csr_load;
    logic [CSR_AW-1:0] o_csr_select;
    logic [XLEN-1:0]   o_csr_data;
    logic              o_jump_DV;
    logic [XLEN-1:0]   o_jump_address;
    logic              o_trap_done;

    modport master (
        output i_boundary, i_pc, i_exc_illegal, i_exc_ebreak, i_exc_ecall,
               i_mret, i_irq_msip, i_irq_mtip, i_irq_meip,
               i_mstatus, i_mie, i_mtvec, i_mepc,
        input  o_trap_take, o_trap_busy, o_csr_load, o_csr_select,
               o_csr_data, o_jump_DV, o_jump_address, o_trap_done
    );

    modport slave (
        input  i_boundary, i_pc, i_exc_illegal, i_exc_ebreak, i_exc_ecall,
               i_mret, i_irq_msip, i_irq_mtip, i_irq_meip,
               i_mstatus, i_mie, i_mtvec, i_mepc,
        output o_trap_take, o_trap_busy, o_csr_load, o_csr_select,
               o_csr_data, o_jump_DV, o_jump_address, o_trap_done
    );
endinterface

// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//  Machine-mode trap sequencer. At an instruction boundary it arbitrates
//  exceptions and enabled interrupts, then writes mstatus, mepc and mcause
//  one per cycle over the shared CSR write port and finally redirects the PC
//  to mtvec. MRET is sequenced as an mstatus restore followed by a jump to
//  mepc. The CPU is held (o_trap_busy) while a sequence is in flight.
//
//  Ports
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)    : boundary/exception/interrupt inputs, CSR snapshots,
//                    CSR write port (o_csr_*), redirect (o_jump_*),
//                    o_trap_take (comb), o_trap_busy, o_trap_done
//
//  Build option
//   TRAP_VECTORED_EN : when defined, interrupts with mtvec[1:0]==01 jump to
//                      base + 4*cause; otherwise every trap jumps to base.
// ---------------------------------------------------------------------------
module trap_controller #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    trap_if.slave  bus
);
    localparam logic [CSR_AW-1:0] CSR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] CSR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = CSR_AW'(12'h342);
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    typedef enum logic [2:0] {
        IDLE, W_MSTATUS, W_MEPC, W_MCAUSE, R_MSTATUS, JUMP
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] target_q;

    logic            irq_mei, irq_msi, irq_mti, irq_any, exc_any;
    logic            is_irq;
    logic [3:0]      cause_code;
    logic [XLEN-1:0] mcause_val, trap_mstatus, mret_mstatus, base, trap_target;
    logic            take_trap, take_mret;
    logic            unused_bits;

    always_comb begin
        irq_mei = bus.i_mstatus[MIE_BIT] & bus.i_mie[11] & bus.i_irq_meip;
        irq_msi = bus.i_mstatus[MIE_BIT] & bus.i_mie[3]  & bus.i_irq_msip;
        irq_mti = bus.i_mstatus[MIE_BIT] & bus.i_mie[7]  & bus.i_irq_mtip;
        irq_any = irq_mei | irq_msi | irq_mti;
        exc_any = bus.i_exc_illegal | bus.i_exc_ebreak | bus.i_exc_ecall;

        is_irq     = 1'b0;
        cause_code = 4'd0;
        if (bus.i_exc_illegal)     cause_code = 4'd2;
        else if (bus.i_exc_ebreak) cause_code = 4'd3;
        else if (bus.i_exc_ecall)  cause_code = 4'd11;
        else if (irq_mei) begin is_irq = 1'b1; cause_code = 4'd11; end
        else if (irq_msi) begin is_irq = 1'b1; cause_code = 4'd3;  end
        else if (irq_mti) begin is_irq = 1'b1; cause_code = 4'd7;  end
        mcause_val = {is_irq, {(XLEN-5){1'b0}}, cause_code};

        // Trap entry: stash MIE into MPIE, disable interrupts, stay in M-mode.
        trap_mstatus           = bus.i_mstatus;
        trap_mstatus[MPIE_BIT] = bus.i_mstatus[MIE_BIT];
        trap_mstatus[MIE_BIT]  = 1'b0;
        trap_mstatus[12:11]    = 2'b11;

        // MRET: restore MIE from MPIE, MPIE set, MPP stays M (M-only core).
        mret_mstatus           = bus.i_mstatus;
        mret_mstatus[MIE_BIT]  = bus.i_mstatus[MPIE_BIT];
        mret_mstatus[MPIE_BIT] = 1'b1;
        mret_mstatus[12:11]    = 2'b11;

        base = {bus.i_mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (is_irq && bus.i_mtvec[1:0] == 2'b01)
            trap_target = base + {{(XLEN-6){1'b0}}, cause_code, 2'b00};
        else
            trap_target = base;
`else
        trap_target = base;
`endif
    end

    // Exceptions beat MRET; MRET beats interrupts (they are re-evaluated at
    // the next boundary once MRET has restored mstatus).
    assign take_trap = (state == IDLE) & bus.i_boundary & (exc_any | (~bus.i_mret & irq_any));
    assign take_mret = (state == IDLE) & bus.i_boundary & ~exc_any & bus.i_mret;

    assign bus.o_trap_take = take_trap | take_mret;
    assign bus.o_trap_busy = (state != IDLE);

`ifdef TRAP_VECTORED_EN
    assign unused_bits = ^{bus.i_pc[1:0], bus.i_mie[31:12], bus.i_mie[10:8],
                           bus.i_mie[6:4], bus.i_mie[2:0]};
`else
    assign unused_bits = ^{bus.i_pc[1:0], bus.i_mie[31:12], bus.i_mie[10:8],
                           bus.i_mie[6:4], bus.i_mie[2:0], bus.i_mtvec[1:0]};
`endif

    // Each state's outputs are registered on entry, so the state name tells
    // what is on the CSR port / redirect during that cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= IDLE;
            pc_q               <= '0;
            cause_q            <= '0;
            target_q           <= '0;
            bus.o_csr_load     <= 1'b0;
            bus.o_csr_select   <= '0;
            bus.o_csr_data     <= '0;
            bus.o_jump_DV      <= 1'b0;
            bus.o_jump_address <= '0;
            bus.o_trap_done    <= 1'b0;
        end else begin
            bus.o_csr_load     <= 1'b0;
            bus.o_csr_select   <= '0;
            bus.o_csr_data     <= '0;
            bus.o_jump_DV      <= 1'b0;
            bus.o_jump_address <= '0;
            bus.o_trap_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_trap) begin
                        state            <= W_MSTATUS;
                        pc_q             <= {bus.i_pc[XLEN-1:2], 2'b00};
                        cause_q          <= mcause_val;
                        target_q         <= trap_target;
                        bus.o_csr_load   <= 1'b1;
                        bus.o_csr_select <= CSR_MSTATUS;
                        bus.o_csr_data   <= trap_mstatus;
                    end else if (take_mret) begin
                        state            <= R_MSTATUS;
                        target_q         <= bus.i_mepc;
                        bus.o_csr_load   <= 1'b1;
                        bus.o_csr_select <= CSR_MSTATUS;
                        bus.o_csr_data   <= mret_mstatus;
                    end
                end
                W_MSTATUS: begin
                    state            <= W_MEPC;
                    bus.o_csr_load   <= 1'b1;
                    bus.o_csr_select <= CSR_MEPC;
                    bus.o_csr_data   <= pc_q;
                end
                W_MEPC: begin
                    state            <= W_MCAUSE;
                    bus.o_csr_load   <= 1'b1;
                    bus.o_csr_select <= CSR_MCAUSE;
                    bus.o_csr_data   <= cause_q;
                end
                W_MCAUSE, R_MSTATUS: begin
                    state              <= JUMP;
                    bus.o_jump_DV      <= 1'b1;
                    bus.o_trap_done    <= 1'b1;
                    bus.o_jump_address <= target_q;
                end
                JUMP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    trap_if bus ();

    trap_controller dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ms, mie, pc, mtvec;
        logic        ill, ebr, ecl, mret, msip, mtip, meip;
        logic [31:0] e_ms, e_pc, e_cause, e_tgt, e_tgt_vec;
    } trap_vec_t;

    // {load, select, data, jump, done, address, busy}
    function automatic logic [79:0] obs();
        return {bus.o_csr_load, bus.o_csr_select, bus.o_csr_data, bus.o_jump_DV,
                bus.o_trap_done, bus.o_jump_address, bus.o_trap_busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_boundary = 0; bus.i_pc = 0; bus.i_exc_illegal = 0; bus.i_exc_ebreak = 0;
        bus.i_exc_ecall = 0; bus.i_mret = 0; bus.i_irq_msip = 0; bus.i_irq_mtip = 0;
        bus.i_irq_meip = 0; bus.i_mstatus = 0; bus.i_mie = 0; bus.i_mtvec = 0; bus.i_mepc = 0;
    endtask

    task automatic apply(input trap_vec_t t);
        bus.i_mstatus = t.ms; bus.i_mie = t.mie; bus.i_pc = t.pc; bus.i_mtvec = t.mtvec;
        bus.i_exc_illegal = t.ill; bus.i_exc_ebreak = t.ebr; bus.i_exc_ecall = t.ecl;
        bus.i_mret = t.mret; bus.i_irq_msip = t.msip; bus.i_irq_mtip = t.mtip;
        bus.i_irq_meip = t.meip;
    endtask

    task automatic test_reset();
        checks++;
        if (obs() !== 80'h0 || bus.o_trap_take !== 1'b0) begin
            errors++;
            $display("FAIL reset got %h take=%0b want 0 take=0", obs(), bus.o_trap_take);
        end
    endtask

    task automatic test_trap_entry();
        trap_vec_t   tv [6];
        logic [31:0] tgt;
        logic [79:0] exp_v;
        tv[0] = '{32'h8, 32'h800, 32'h100, 32'h2000_0001, 0,0,0,0, 0,0,1,
                  32'h1880, 32'h100, 32'h8000_000B, 32'h2000_0000, 32'h2000_002C};
        tv[1] = '{32'h0, 32'h0, 32'h40, 32'h2000_0001, 0,0,1,0, 0,0,0,
                  32'h1800, 32'h40, 32'hB, 32'h2000_0000, 32'h2000_0000};
        tv[2] = '{32'h8, 32'h800, 32'h204, 32'h1000_0000, 1,0,1,0, 0,0,1,
                  32'h1880, 32'h204, 32'h2, 32'h1000_0000, 32'h1000_0000};
        tv[3] = '{32'h8, 32'h888, 32'h80, 32'h3000_0000, 0,0,0,0, 1,1,1,
                  32'h1880, 32'h80, 32'h8000_000B, 32'h3000_0000, 32'h3000_0000};
        tv[4] = '{32'h8, 32'h88, 32'h13, 32'h3000_0001, 0,0,0,0, 1,1,0,
                  32'h1880, 32'h10, 32'h8000_0003, 32'h3000_0000, 32'h3000_000C};
        tv[5] = '{32'h1888, 32'h0, 32'h44, 32'h2000_0002, 0,1,0,1, 0,0,0,
                  32'h1880, 32'h44, 32'h3, 32'h2000_0000, 32'h2000_0000};
        for (int v = 0; v < 6; v++) begin
`ifdef TRAP_VECTORED_EN
            tgt = tv[v].e_tgt_vec;
`else
            tgt = tv[v].e_tgt;
`endif
            clear_inputs();
            apply(tv[v]);
            bus.i_boundary = 1;
            #1;
            checks++;
            if (bus.o_trap_take !== 1'b1) begin
                errors++;
                $display("FAIL trap%0d_take got %0b want 1", v, bus.o_trap_take);
            end
            step();
            clear_inputs();
            for (int k = 0; k < 5; k++) begin
                case (k)
                    0:       exp_v = {1'b1, 12'h300, tv[v].e_ms,    1'b0, 1'b0, 32'h0, 1'b1};
                    1:       exp_v = {1'b1, 12'h341, tv[v].e_pc,    1'b0, 1'b0, 32'h0, 1'b1};
                    2:       exp_v = {1'b1, 12'h342, tv[v].e_cause, 1'b0, 1'b0, 32'h0, 1'b1};
                    3:       exp_v = {1'b0, 12'h000, 32'h0, 1'b1, 1'b1, tgt, 1'b1};
                    default: exp_v = 80'h0;
                endcase
                checks++;
                if (obs() !== exp_v) begin
                    errors++;
                    $display("FAIL trap%0d_cyc%0d got %h want %h", v, k + 1, obs(), exp_v);
                end
                step();
            end
        end
    endtask

    task automatic test_mret();
        logic [31:0] ms  [2];
        logic [31:0] mep [2];
        logic [31:0] ems [2];
        logic [79:0] exp_v;
        ms  = '{32'h1880, 32'h8};
        mep = '{32'h300, 32'h1234};
        ems = '{32'h1888, 32'h1880};
        for (int v = 0; v < 2; v++) begin
            clear_inputs();
            bus.i_mstatus = ms[v]; bus.i_mepc = mep[v]; bus.i_mret = 1;
            if (v == 1) begin bus.i_mie = 32'h800; bus.i_irq_meip = 1; end
            bus.i_boundary = 1;
            #1;
            checks++;
            if (bus.o_trap_take !== 1'b1) begin
                errors++;
                $display("FAIL mret%0d_take got %0b want 1", v, bus.o_trap_take);
            end
            step();
            clear_inputs();
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0:       exp_v = {1'b1, 12'h300, ems[v], 1'b0, 1'b0, 32'h0, 1'b1};
                    1:       exp_v = {1'b0, 12'h000, 32'h0, 1'b1, 1'b1, mep[v], 1'b1};
                    default: exp_v = 80'h0;
                endcase
                checks++;
                if (obs() !== exp_v) begin
                    errors++;
                    $display("FAIL mret%0d_cyc%0d got %h want %h", v, k + 1, obs(), exp_v);
                end
                step();
            end
        end
    endtask

    task automatic test_masked_irq();
        clear_inputs();
        bus.i_mie = 32'h888; bus.i_irq_meip = 1; bus.i_irq_mtip = 1; bus.i_irq_msip = 1;
        bus.i_pc = 32'h100; bus.i_mtvec = 32'h2000_0000;
        bus.i_boundary = 1;
        #1;
        checks++;
        if (bus.o_trap_take !== 1'b0) begin
            errors++;
            $display("FAIL masked_take got %0b want 0", bus.o_trap_take);
        end
        step();
        bus.i_boundary = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs() !== 80'h0) begin
                errors++;
                $display("FAIL masked_cyc%0d got %h want 0", k + 1, obs());
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        logic [79:0] exp_v;
        clear_inputs();
        bus.i_mstatus = 32'h8; bus.i_mie = 32'h800; bus.i_irq_meip = 1;
        bus.i_pc = 32'h100; bus.i_mtvec = 32'h2000_0000;
        bus.i_boundary = 1;
        step();
        clear_inputs();
        step();
        exp_v = {1'b1, 12'h341, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL abort_pre got %h want %h", obs(), exp_v);
        end
        rst_n = 0;
        #1;
        checks++;
        if (obs() !== 80'h0) begin
            errors++;
            $display("FAIL abort_now got %h want 0", obs());
        end
        step();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs() !== 80'h0) begin
                errors++;
                $display("FAIL abort_after%0d got %h want 0", k, obs());
            end
            step();
        end
        // A clean trap right after the aborted one.
        bus.i_exc_ecall = 1; bus.i_pc = 32'h40; bus.i_mtvec = 32'h2000_0001;
        bus.i_boundary = 1;
        step();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       exp_v = {1'b1, 12'h300, 32'h1800, 1'b0, 1'b0, 32'h0, 1'b1};
                1:       exp_v = {1'b1, 12'h341, 32'h40,   1'b0, 1'b0, 32'h0, 1'b1};
                2:       exp_v = {1'b1, 12'h342, 32'hB,    1'b0, 1'b0, 32'h0, 1'b1};
                default: exp_v = {1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h2000_0000, 1'b1};
            endcase
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL clean_cyc%0d got %h want %h", k + 1, obs(), exp_v);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] exp_v;
        clear_inputs();
        bus.i_exc_ecall = 1; bus.i_pc = 32'h40; bus.i_mtvec = 32'h2000_0000;
        bus.i_boundary = 1;
        step();
        clear_inputs();
        // Exception pulse while busy must be dropped.
        bus.i_exc_illegal = 1; bus.i_pc = 32'h999; bus.i_boundary = 1;
        #1;
        checks++;
        if (bus.o_trap_take !== 1'b0) begin
            errors++;
            $display("FAIL busy_take got %0b want 0", bus.o_trap_take);
        end
        step();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       exp_v = {1'b1, 12'h341, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1};
                1:       exp_v = {1'b1, 12'h342, 32'hB,  1'b0, 1'b0, 32'h0, 1'b1};
                default: exp_v = {1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h2000_0000, 1'b1};
            endcase
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL b2b_cyc%0d got %h want %h", k + 2, obs(), exp_v);
            end
            step();
        end
        // First idle cycle: a new boundary is accepted immediately.
        bus.i_exc_ebreak = 1; bus.i_pc = 32'h50; bus.i_mtvec = 32'h2000_0000;
        bus.i_boundary = 1;
        #1;
        checks++;
        if (bus.o_trap_take !== 1'b1) begin
            errors++;
            $display("FAIL b2b_take got %0b want 1", bus.o_trap_take);
        end
        step();
        clear_inputs();
        exp_v = {1'b1, 12'h300, 32'h1800, 1'b0, 1'b0, 32'h0, 1'b1};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL b2b_second got %h want %h", obs(), exp_v);
        end
        step(); step();
        exp_v = {1'b1, 12'h342, 32'h3, 1'b0, 1'b0, 32'h0, 1'b1};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL b2b_cause got %h want %h", obs(), exp_v);
        end
        step(); step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        clear_inputs();
        step();
        test_reset();
        step();
        rst_n = 1;
        step();
        test_trap_entry();
        test_mret();
        test_masked_irq();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
